// File: rtl/reg_alu_pkg.sv
// Shared widths, instruction field positions and the decoded instruction type
// for the reg_alu instruction sequencer.
package reg_alu_pkg;

  localparam int unsigned INSTR_W = 29;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned OP_W    = 2;

  // Field positions inside the 29-bit instruction word (MSB first)
  localparam int unsigned SEL_BIT = 28;
  localparam int unsigned WR_BIT  = 27;
  localparam int unsigned OP_MSB  = 26;
  localparam int unsigned OP_LSB  = 25;
  localparam int unsigned RDA_MSB = 24;
  localparam int unsigned RDA_LSB = 22;
  localparam int unsigned RDB_MSB = 21;
  localparam int unsigned RDB_LSB = 19;
  localparam int unsigned WA_MSB  = 18;
  localparam int unsigned WA_LSB  = 16;
  localparam int unsigned DIN_MSB = 15;
  localparam int unsigned DIN_LSB = 0;

  // Control bundle driven onto the reg_alu pins
  typedef struct packed {
    logic              sel;
    logic              wr;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] rd_a;
    logic [ADDR_W-1:0] rd_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] d_in;
  } instr_t;

  // Split a raw instruction word into its named fields
  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] w);
    instr_t r;
    r.sel     = w[SEL_BIT];
    r.wr      = w[WR_BIT];
    r.op      = w[OP_MSB:OP_LSB];
    r.rd_a    = w[RDA_MSB:RDA_LSB];
    r.rd_b    = w[RDB_MSB:RDB_LSB];
    r.wr_addr = w[WA_MSB:WA_LSB];
    r.d_in    = w[DIN_MSB:DIN_LSB];
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous instruction FIFO; full/empty flags are kept as flops.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_full,
  output logic             empty,
  output logic             empty_nxt_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             not_full_q, not_full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  assign do_push = push && not_full_q;
  assign do_pop  = pop && !empty_q;

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    not_full_d = (count_d != CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
      empty_q    <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata       = mem_q[rd_ptr_q];
  assign not_full    = not_full_q;
  assign empty       = empty_q;
  assign empty_nxt_c = empty_d;

endmodule

// File: rtl/reg_alu_seq.sv
// Instruction sequencer: buffers instruction words, issues one per cycle onto
// the reg_alu control pins and captures the pre-write read/ALU outputs.
module reg_alu_seq
  import reg_alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               alu_sel,
  output logic               alu_wr,
  output logic [OP_W-1:0]    alu_op,
  output logic [ADDR_W-1:0]  alu_rd_addr_a,
  output logic [ADDR_W-1:0]  alu_rd_addr_b,
  output logic [ADDR_W-1:0]  alu_wr_addr,
  output logic [DATA_W-1:0]  alu_d_in,
  input  logic [DATA_W-1:0]  alu_d_out_a,
  input  logic [DATA_W-1:0]  alu_d_out_b,
  input  logic               alu_cout,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_a,
  output logic [DATA_W-1:0]  res_b,
  output logic               res_cout,
  output logic               busy,
  output logic [CNT_W-1:0]   issued_cnt
);

  logic [INSTR_W-1:0] fifo_rdata;
  logic               fifo_not_full;
  logic               fifo_empty;
  logic               fifo_empty_nxt;
  logic               can_issue;
  instr_t             head;

  instr_t             alu_q, alu_d;
  logic               issue_q, issue_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [DATA_W-1:0]  res_a_q, res_a_d;
  logic [DATA_W-1:0]  res_b_q, res_b_d;
  logic               res_cout_q, res_cout_d;
  logic               busy_q, busy_d;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .push        (in_valid),
    .wdata       (in_instr),
    .pop         (can_issue),
    .rdata       (fifo_rdata),
    .not_full    (fifo_not_full),
    .empty       (fifo_empty),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Issue only when the result slot is free or being drained this edge
  assign can_issue = !fifo_empty && (!res_valid_q || res_ready);
  assign head      = unpack_instr(fifo_rdata);

  // Issue, capture and result-handshake next-state logic
  always_comb begin
    alu_d       = '0;
    issue_d     = can_issue;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_a_d     = res_a_q;
    res_b_d     = res_b_q;
    res_cout_d  = res_cout_q;
    busy_d      = !fifo_empty_nxt || can_issue;

    if (can_issue) begin
      alu_d = head;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Reads sampled here are pre-write: the reg_alu write lands on this same edge
    if (issue_q) begin
      res_valid_d = 1'b1;
      res_a_d     = alu_d_out_a;
      res_b_d     = alu_d_out_b;
      res_cout_d  = alu_cout;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  // Sequencer state registers; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_q       <= '0;
      issue_q     <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_a_q     <= '0;
      res_b_q     <= '0;
      res_cout_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      alu_q       <= alu_d;
      issue_q     <= issue_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_a_q     <= res_a_d;
      res_b_q     <= res_b_d;
      res_cout_q  <= res_cout_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready      = fifo_not_full;
  assign alu_sel       = alu_q.sel;
  assign alu_wr        = alu_q.wr;
  assign alu_op        = alu_q.op;
  assign alu_rd_addr_a = alu_q.rd_a;
  assign alu_rd_addr_b = alu_q.rd_b;
  assign alu_wr_addr   = alu_q.wr_addr;
  assign alu_d_in      = alu_q.d_in;
  assign res_valid     = res_valid_q;
  assign res_a         = res_a_q;
  assign res_b         = res_b_q;
  assign res_cout      = res_cout_q;
  assign busy          = busy_q;
  assign issued_cnt    = cnt_q;

endmodule

// File: tb/tb_reg_alu_seq.sv
// Directed bench for reg_alu_seq with a small behavioural reg_alu on the datapath pins.
module tb_reg_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [28:0] in_instr;
  logic        alu_sel, alu_wr;
  logic [1:0]  alu_op;
  logic [2:0]  alu_rd_addr_a, alu_rd_addr_b, alu_wr_addr;
  logic [15:0] alu_d_in;
  logic [15:0] alu_d_out_a, alu_d_out_b;
  logic        alu_cout;
  logic        res_valid, res_ready;
  logic [15:0] res_a, res_b;
  logic        res_cout;
  logic        busy;
  logic [7:0]  issued_cnt;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  reg_alu_seq #(.DEPTH(4), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .alu_sel       (alu_sel),
    .alu_wr        (alu_wr),
    .alu_op        (alu_op),
    .alu_rd_addr_a (alu_rd_addr_a),
    .alu_rd_addr_b (alu_rd_addr_b),
    .alu_wr_addr   (alu_wr_addr),
    .alu_d_in      (alu_d_in),
    .alu_d_out_a   (alu_d_out_a),
    .alu_d_out_b   (alu_d_out_b),
    .alu_cout      (alu_cout),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_a         (res_a),
    .res_b         (res_b),
    .res_cout      (res_cout),
    .busy          (busy),
    .issued_cnt    (issued_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural register file: async reads, write on the rising edge
  logic [15:0] regs [8] = '{default: 16'h0000};
  logic [16:0] sum;
  always_comb begin
    alu_d_out_a = regs[alu_rd_addr_a];
    alu_d_out_b = regs[alu_rd_addr_b];
    sum         = {1'b0, alu_d_out_a} + {1'b0, alu_d_out_b};
    alu_cout    = sum[16];
  end
  always @(posedge clk) begin
    if (alu_wr) regs[alu_wr_addr] <= alu_sel ? sum[15:0] : alu_d_in;
  end

  function automatic logic [28:0] mk(input logic sel, input logic wr, input logic [1:0] op,
                                     input logic [2:0] ra, input logic [2:0] rb,
                                     input logic [2:0] wa, input logic [15:0] din);
    return {sel, wr, op, ra, rb, wa, din};
  endfunction

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (in_ready !== 1'b1)     begin n_miss++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    n_vec++; if (res_valid !== 1'b0)    begin n_miss++; $display("FAIL reset_res_valid got=%0h exp=0", res_valid); end
    n_vec++; if (busy !== 1'b0)         begin n_miss++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    n_vec++; if (issued_cnt !== 8'h00)  begin n_miss++; $display("FAIL reset_cnt got=%0h exp=0", issued_cnt); end
    n_vec++; if (alu_wr !== 1'b0 || alu_d_in !== 16'h0) begin n_miss++; $display("FAIL reset_alu got=%0h/%0h exp=0/0", alu_wr, alu_d_in); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    in_instr = mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd3, 16'hcdef);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_vec++; if (alu_wr !== 1'b1 || alu_wr_addr !== 3'd3) begin n_miss++; $display("FAIL rmid_issue got=%0h/%0h exp=1/3", alu_wr, alu_wr_addr); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (alu_wr !== 1'b0)       begin n_miss++; $display("FAIL rmid_alu_wr got=%0h exp=0", alu_wr); end
    n_vec++; if (res_valid !== 1'b0)    begin n_miss++; $display("FAIL rmid_res_valid got=%0h exp=0", res_valid); end
    n_vec++; if (issued_cnt !== 8'h00)  begin n_miss++; $display("FAIL rmid_cnt got=%0h exp=0", issued_cnt); end
    n_vec++; if (in_ready !== 1'b1)     begin n_miss++; $display("FAIL rmid_in_ready got=%0h exp=1", in_ready); end
    step();
    rst_n = 1'b1;
    n_vec++; if (regs[3] !== 16'h0000)  begin n_miss++; $display("FAIL rmid_no_write got=%0h exp=0", regs[3]); end
    step();
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_miss++; $display("FAIL rmid_after got=%0h/%0h exp=0/0", res_valid, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_instr = mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd3, 16'hcdef);
    in_valid = 1'b1;
    step();
    in_instr = mk(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 3'd7, 16'h3210);
    step();
    n_vec++; if (alu_wr !== 1'b1 || alu_wr_addr !== 3'd3 || alu_d_in !== 16'hcdef) begin n_miss++; $display("FAIL b2b_i0 got=%0h/%0h/%0h exp=1/3/cdef", alu_wr, alu_wr_addr, alu_d_in); end
    in_instr = mk(1'b0, 1'b0, 2'd0, 3'd3, 3'd7, 3'd0, 16'h0000);
    step();
    n_vec++; if (alu_wr !== 1'b1 || alu_wr_addr !== 3'd7 || alu_d_in !== 16'h3210) begin n_miss++; $display("FAIL b2b_i1 got=%0h/%0h/%0h exp=1/7/3210", alu_wr, alu_wr_addr, alu_d_in); end
    in_valid = 1'b0;
    step();
    n_vec++; if (alu_wr !== 1'b0 || alu_rd_addr_a !== 3'd3 || alu_rd_addr_b !== 3'd7) begin n_miss++; $display("FAIL b2b_i2 got=%0h/%0h/%0h exp=0/3/7", alu_wr, alu_rd_addr_a, alu_rd_addr_b); end
    step();
    n_vec++; if (res_valid !== 1'b1 || res_a !== 16'hcdef || res_b !== 16'h3210 || res_cout !== 1'b0) begin n_miss++; $display("FAIL b2b_res got=%0h/%0h/%0h/%0h exp=1/cdef/3210/0", res_valid, res_a, res_b, res_cout); end
    n_vec++; if (issued_cnt !== 8'd3)   begin n_miss++; $display("FAIL b2b_cnt got=%0d exp=3", issued_cnt); end
    step();
    n_vec++; if (res_valid !== 1'b0 || busy !== 1'b0 || alu_rd_addr_a !== 3'd0) begin n_miss++; $display("FAIL b2b_idle got=%0h/%0h/%0h exp=0/0/0", res_valid, busy, alu_rd_addr_a); end
  endtask

  task automatic test_full();
    do_reset();
    res_ready = 1'b0;
    in_instr  = mk(1'b0, 1'b0, 2'd0, 3'd1, 3'd2, 3'd0, 16'h00aa);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    step();
    step();
    n_vec++; if (res_valid !== 1'b1)    begin n_miss++; $display("FAIL full_pending got=%0h exp=1", res_valid); end
    for (int k = 0; k < 4; k++) begin
      in_instr = mk(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h1000 + 16'(k));
      in_valid = 1'b1;
      step();
    end
    n_vec++; if (in_ready !== 1'b0 || busy !== 1'b1 || alu_d_in !== 16'h0) begin n_miss++; $display("FAIL full_held got=%0h/%0h/%0h exp=0/1/0", in_ready, busy, alu_d_in); end
    in_instr = mk(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h1004);
    for (int k = 0; k < 3; k++) step();
    n_vec++; if (in_ready !== 1'b0 || res_valid !== 1'b1 || issued_cnt !== 8'd1) begin n_miss++; $display("FAIL full_blocked got=%0h/%0h/%0d exp=0/1/1", in_ready, res_valid, issued_cnt); end
    res_ready = 1'b1;
    step();
    n_vec++; if (alu_d_in !== 16'h1000 || in_ready !== 1'b1 || res_valid !== 1'b0) begin n_miss++; $display("FAIL full_pop0 got=%0h/%0h/%0h exp=1000/1/0", alu_d_in, in_ready, res_valid); end
    step();
    in_valid = 1'b0;
    n_vec++; if (alu_d_in !== 16'h1001 || res_valid !== 1'b1) begin n_miss++; $display("FAIL full_pop1 got=%0h/%0h exp=1001/1", alu_d_in, res_valid); end
    for (int k = 2; k < 5; k++) begin
      step();
      n_vec++; if (alu_d_in !== 16'h1000 + 16'(k)) begin n_miss++; $display("FAIL full_pop%0d got=%0h exp=%0h", k, alu_d_in, 16'h1000 + 16'(k)); end
    end
    step();
    n_vec++; if (alu_d_in !== 16'h0 || issued_cnt !== 8'd6) begin n_miss++; $display("FAIL full_end got=%0h/%0d exp=0/6", alu_d_in, issued_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 1'b0;
    in_instr  = mk(1'b0, 1'b0, 2'd0, 3'd3, 3'd3, 3'd0, 16'h0000);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    step();
    step();
    in_instr  = mk(1'b0, 1'b0, 2'd1, 3'd5, 3'd6, 3'd0, 16'h0bb0);
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_vec++; if (res_valid !== 1'b1 || res_a !== 16'hcdef || res_b !== 16'hcdef || res_cout !== 1'b1) begin n_miss++; $display("FAIL bp_res%0d got=%0h/%0h/%0h/%0h exp=1/cdef/cdef/1", k, res_valid, res_a, res_b, res_cout); end
      n_vec++; if (alu_d_in !== 16'h0 || alu_op !== 2'd0 || alu_rd_addr_a !== 3'd0 || busy !== 1'b1) begin n_miss++; $display("FAIL bp_alu%0d got=%0h/%0h/%0h/%0h exp=0/0/0/1", k, alu_d_in, alu_op, alu_rd_addr_a, busy); end
    end
    res_ready = 1'b1;
    step();
    n_vec++; if (alu_d_in !== 16'h0bb0 || alu_op !== 2'd1 || issued_cnt !== 8'd2 || res_valid !== 1'b0) begin n_miss++; $display("FAIL bp_release got=%0h/%0h/%0d/%0h exp=0bb0/1/2/0", alu_d_in, alu_op, issued_cnt, res_valid); end
    step();
    n_vec++; if (res_valid !== 1'b1 || busy !== 1'b0) begin n_miss++; $display("FAIL bp_final got=%0h/%0h exp=1/0", res_valid, busy); end
  endtask

  task automatic test_bubble();
    do_reset();
    in_instr = mk(1'b0, 1'b0, 2'd3, 3'd3, 3'd7, 3'd0, 16'h5a5a);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++; if (busy !== 1'b1 || alu_d_in !== 16'h0) begin n_miss++; $display("FAIL bub_queued got=%0h/%0h exp=1/0", busy, alu_d_in); end
    step();
    n_vec++; if (alu_d_in !== 16'h5a5a || alu_op !== 2'd3 || busy !== 1'b1) begin n_miss++; $display("FAIL bub_issue got=%0h/%0h/%0h exp=5a5a/3/1", alu_d_in, alu_op, busy); end
    step();
    n_vec++; if (alu_d_in !== 16'h0 || alu_op !== 2'd0 || alu_rd_addr_b !== 3'd0 || busy !== 1'b0) begin n_miss++; $display("FAIL bub_after got=%0h/%0h/%0h/%0h exp=0/0/0/0", alu_d_in, alu_op, alu_rd_addr_b, busy); end
    n_vec++; if (res_valid !== 1'b1 || res_b !== 16'h3210) begin n_miss++; $display("FAIL bub_res got=%0h/%0h exp=1/3210", res_valid, res_b); end
    step();
    n_vec++; if (res_valid !== 1'b0)    begin n_miss++; $display("FAIL bub_drain got=%0h exp=0", res_valid); end
  endtask

  task automatic test_wrap();
    logic ready_ok;
    ready_ok = 1'b1;
    do_reset();
    in_instr = mk(1'b0, 1'b0, 2'd0, 3'd0, 3'd0, 3'd0, 16'h0001);
    in_valid = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      step();
      if (in_ready !== 1'b1) ready_ok = 1'b0;
      if (i == 129) begin
        n_vec++; if (issued_cnt !== 8'h80) begin n_miss++; $display("FAIL wrap_mid got=%0h exp=80", issued_cnt); end
      end
    end
    in_valid = 1'b0;
    n_vec++; if (ready_ok !== 1'b1) begin n_miss++; $display("FAIL wrap_in_ready got=%0h exp=1", ready_ok); end
    step();
    n_vec++; if (issued_cnt !== 8'h00)  begin n_miss++; $display("FAIL wrap_cnt got=%0h exp=0", issued_cnt); end
    step();
    n_vec++; if (busy !== 1'b0)         begin n_miss++; $display("FAIL wrap_idle got=%0h exp=0", busy); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    res_ready = 1'b1;
    #2;
    test_reset();
    test_reset_mid_op();
    test_back_to_back();
    test_full();
    test_backpressure();
    test_bubble();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/reg_alu_seq.md
Name: reg_alu_seq

Overview:
Instruction sequencer for the 8x16-bit register-file/ALU datapath (reg_alu). It accepts 29-bit instruction words over a valid/ready handshake and buffers them in a small FIFO. It issues at most one instruction per cycle onto the datapath control pins, captures the read/ALU outputs, and presents them as a result with backpressure. It is the single owner of the reg_alu control inputs.

Parameters:
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
CNT_W, 8, width of the issued-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instruction word valid
in_ready  out  1  FIFO can accept; equals !full
in_instr  in  29  {sel, wr, op[1:0], rd_a[2:0], rd_b[2:0], wr_addr[2:0], d_in[15:0]}, MSB first
alu_sel  out  1  to reg_alu sel
alu_wr  out  1  to reg_alu wr
alu_op  out  2  to reg_alu op
alu_rd_addr_a  out  3  to reg_alu rd_addr_a
alu_rd_addr_b  out  3  to reg_alu rd_addr_b
alu_wr_addr  out  3  to reg_alu wr_addr
alu_d_in  out  16  to reg_alu d_in
alu_d_out_a  in  16  from reg_alu d_out_a
alu_d_out_b  in  16  from reg_alu d_out_b
alu_cout  in  1  from reg_alu cout
res_valid  out  1  result registers hold an unconsumed result
res_ready  in  1  consumer accepts result
res_a  out  16  captured d_out_a
res_b  out  16  captured d_out_b
res_cout  out  1  captured cout
busy  out  1  FIFO non-empty or issue in progress
issued_cnt  out  CNT_W  instructions issued, wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous and active-low: reset=0 immediately clears the FIFO (empty), all alu_* outputs, res_valid, res_a/b/cout and issued_cnt; busy=0; in_ready=1. An in-flight instruction is discarded with no write and no result. Release is synchronous to the next clk edge.
- Push: when in_valid && in_ready at an edge, in_instr is written to the FIFO tail. in_ready=0 when DEPTH entries are held; there is no pass-through on a full FIFO even if a pop occurs in the same cycle.
- can_issue = FIFO non-empty && (!res_valid || res_ready).
- Issue: on an edge with can_issue, pop the head into the alu_* output registers and increment issued_cnt. During the following cycle ("issue cycle"), alu_* carry the instruction fields unchanged. With no issue, all alu_* are registered to 0 (bubble; alu_wr=0 guarantees no write).
- Capture: at the edge that ends an issue cycle, res_a/res_b/res_cout <= alu_d_out_a/b/cout and res_valid <= 1. These are pre-write read values, because the reg_alu write lands on that same edge.
- Result handshake: the result is consumed at an edge with res_valid && res_ready. res_valid then drops unless a new capture occurs on that edge, in which case the new result replaces the old one with no gap. While res_valid && !res_ready, res_* hold stable and no issue occurs.
- Latency: instruction accepted at edge N (FIFO was empty) -> popped at edge N+1 -> on alu_* during cycle N+1..N+2 -> res_valid at edge N+2. Throughput is 1 instruction/cycle when res_ready=1.
- Simultaneous push and pop: allowed when not full; occupancy is unchanged.
- Control state is derived, not encoded:
  - IDLE: FIFO empty, no issue cycle.
  - ISSUE: issue cycle active.
  - STALL: res_valid && !res_ready && FIFO non-empty.
  - Transitions follow can_issue.
- busy = FIFO non-empty || issue cycle active.

Decomposition:
- Package reg_alu_pkg:
  - INSTR_W=29.
  - Field MSB/LSB constants: SEL=28, WR=27, OP=26:25, RDA=24:22, RDB=21:19, WA=18:16, DIN=15:0.
  - Widths: DATA_W=16, ADDR_W=3, OP_W=2.
- One sub-module, instr_fifo: synchronous FIFO (DEPTH, width INSTR_W, full/empty/push/pop) with async active-low reset. Issue and result logic stay in reg_alu_seq.

Test Plan:
- Reset mid-op: push {0,1,00,o0,o0,o3,16'hcdef}, assert reset=0 during the issue cycle -> alu_wr falls to 0 immediately, res_valid=0, issued_cnt=0, in_ready=1.
- Back-to-back: res_ready=1. Push write r3=16'hcdef, write r7=16'h3210, then read instr with rd_a=3, rd_b=7 on consecutive cycles -> alu_* show them on consecutive cycles; the third result gives res_a=16'hcdef, res_b=16'h3210; issued_cnt=3.
- Full: res_ready=0 and one result pending. Push 5 instrs -> in_ready=0 after 4 are held; the 5th is held off until res_ready=1, then one pop occurs per edge.
- Backpressure: res_valid=1, res_ready=0 for 5 cycles -> res_a/b/cout stable, all alu_* = 0, busy=1. Raising res_ready -> next issue on that edge.
- Bubble: a single instr followed by an empty FIFO -> one issue cycle, then alu_* all 0, busy=0 one cycle after the last issue cycle.
- Counter wrap (CNT_W=8): issue 256 instrs -> issued_cnt returns to 8'h00.
